// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file read bypass.
package regfile_pkg;

    localparam int REGFILE_DATA_W    = 64;
    localparam int REGFILE_IDX_W     = 5;
    localparam int REGFILE_BYTES     = 8;
    localparam int REGFILE_NUM_READ  = 8;
    localparam int REGFILE_NUM_WRITE = 4;

    typedef logic [REGFILE_BYTES-1:0] regfile_mask_t;

    typedef struct packed {
        logic                      write;
        logic [REGFILE_IDX_W-1:0]  address;
        logic [REGFILE_DATA_W-1:0] value;
        regfile_mask_t             byteMask;
    } regfile_wr_t;

endpackage

// File: rtl/regfile_bypass_lane.sv
// One read lane: merges captured same-cycle write bytes over SRAM read data.
module regfile_bypass_lane
    import regfile_pkg::*;
#(
    parameter int NUM_WRITE = REGFILE_NUM_WRITE
) (
    input  logic [REGFILE_IDX_W-1:0]  rd_index,
    input  logic [REGFILE_DATA_W-1:0] sram_data,
    input  regfile_wr_t [NUM_WRITE-1:0] wr,
    output logic [REGFILE_DATA_W-1:0] value,
    output logic                      hit
);

    // Ascending port order lets the highest-numbered matching port win each byte.
    always_comb begin
        value = sram_data;
        hit   = 1'b0;
        for (int j = 0; j < NUM_WRITE; j++) begin
            if (wr[j].write && (wr[j].address == rd_index)) begin
                for (int k = 0; k < REGFILE_BYTES; k++) begin
                    if (wr[j].byteMask[k]) begin
                        value[8*k +: 8] = wr[j].value[8*k +: 8];
                        hit             = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/regfile_read_bypass.sv
// Read-during-write bypass behind the 32x64 register SRAM (1-cycle latency).
// Optional REGFILE_BYPASS_CNT_EN adds the saturating bypass_hits counter.
module regfile_read_bypass
    import regfile_pkg::*;
#(
    parameter int NUM_READ  = REGFILE_NUM_READ,
    parameter int NUM_WRITE = REGFILE_NUM_WRITE,
    parameter int ADDR_W    = 7,
    parameter int IDX_W     = REGFILE_IDX_W,
    parameter int DATA_W    = REGFILE_DATA_W
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [NUM_READ-1:0]           rd_valid,
    input  logic [NUM_READ*ADDR_W-1:0]    rd_address,
    input  logic [NUM_WRITE-1:0]          wr_write,
    input  logic [NUM_WRITE*ADDR_W-1:0]   wr_address,
    input  logic [NUM_WRITE*DATA_W-1:0]   wr_value,
    input  logic [NUM_WRITE*DATA_W/8-1:0] wr_byteMask,
    input  logic [NUM_READ*DATA_W-1:0]    sram_data,
    output logic [NUM_READ-1:0]           out_valid,
    output logic [NUM_READ*DATA_W-1:0]    out_value
`ifdef REGFILE_BYPASS_CNT_EN
    ,
    output logic [31:0]                   bypass_hits
`endif
);

    localparam int BYTES = DATA_W / 8;

    logic [NUM_READ-1:0]            vld_p1;
    logic [NUM_READ-1:0][IDX_W-1:0] rd_idx_p1;
    regfile_wr_t [NUM_WRITE-1:0]    wr_p1;
    logic [NUM_READ-1:0]            lane_hit;

    // Upper address bits alias onto the same SRAM row and are deliberately dropped.
    logic [NUM_READ+NUM_WRITE-1:0]  unused_addr_hi;
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd_hi
        assign unused_addr_hi[i] = ^rd_address[i*ADDR_W+IDX_W +: ADDR_W-IDX_W];
    end
    for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wr_hi
        assign unused_addr_hi[NUM_READ+j] = ^wr_address[j*ADDR_W+IDX_W +: ADDR_W-IDX_W];
    end

    // ---- stage p0 -> p1: capture read requests and same-cycle writes ----
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            vld_p1    <= '0;
            rd_idx_p1 <= '0;
            wr_p1     <= '0;
        end else begin
            vld_p1 <= rd_valid;
            for (int i = 0; i < NUM_READ; i++) begin
                rd_idx_p1[i] <= rd_address[i*ADDR_W +: IDX_W];
            end
            for (int j = 0; j < NUM_WRITE; j++) begin
                wr_p1[j].write    <= wr_write[j];
                wr_p1[j].address  <= wr_address[j*ADDR_W +: IDX_W];
                wr_p1[j].value    <= wr_value[j*DATA_W +: DATA_W];
                wr_p1[j].byteMask <= wr_write[j] ? wr_byteMask[j*BYTES +: BYTES] : '0;
            end
        end
    end

    // ---- stage p1: merge against SRAM data arriving this cycle ----
    for (genvar i = 0; i < NUM_READ; i++) begin : g_lane
        regfile_bypass_lane #(
            .NUM_WRITE (NUM_WRITE)
        ) u_lane (
            .rd_index  (rd_idx_p1[i]),
            .sram_data (sram_data[i*DATA_W +: DATA_W]),
            .wr        (wr_p1),
            .value     (out_value[i*DATA_W +: DATA_W]),
            .hit       (lane_hit[i])
        );
    end

    assign out_valid = vld_p1;

`ifdef REGFILE_BYPASS_CNT_EN
    localparam int CNT_W = $clog2(NUM_READ + 1);

    logic [CNT_W-1:0] hit_count;
    logic [32:0]      hit_sum;
    logic [31:0]      hit_total;

    always_comb begin
        hit_count = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            if (vld_p1[i] && lane_hit[i]) begin
                hit_count = hit_count + CNT_W'(1);
            end
        end
    end

    assign hit_sum = {1'b0, hit_total} + 33'(hit_count);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hit_total <= '0;
        end else begin
            hit_total <= hit_sum[32] ? '1 : hit_sum[31:0];
        end
    end

    assign bypass_hits = hit_total;
`else
    logic unused_lane_hit;
    assign unused_lane_hit = ^lane_hit;
`endif

endmodule

// File: doc/regfile_read_bypass.md
Name: regfile_read_bypass

Overview:
- Sits directly downstream of the 32x64 register SRAM (8 sync read ports, 4 byte-masked write ports) in the mock ALU register file.
- Consumes the SRAM's registered read data and corrects read-during-write collisions. It forwards bytes written in the same cycle a read address was presented, so each read lane returns post-write data.
- Also tracks a per-lane valid through the 1-cycle SRAM read latency.

Parameters:
- NUM_READ, 8, number of read lanes.
- NUM_WRITE, 4, number of write ports.
- ADDR_W, 7, external address width.
- IDX_W, 5, address bits actually decoded; upper bits ignored, matching SRAM aliasing.
- DATA_W, 64, data width; must be a multiple of 8.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rd_valid  in  NUM_READ  lane i read issued this cycle.
- rd_address  in  NUM_READ x ADDR_W  read address, same cycle as SRAM R addr.
- wr_write  in  NUM_WRITE  write enable, same cycle as SRAM W en.
- wr_address  in  NUM_WRITE x ADDR_W  write address.
- wr_value  in  NUM_WRITE x DATA_W  write data.
- wr_byteMask  in  NUM_WRITE x DATA_W/8  byte enables; bit k covers data[8k+7:8k].
- sram_data  in  NUM_READ x DATA_W  SRAM R data, valid one cycle after address.
- out_valid  out  NUM_READ  registered rd_valid.
- out_value  out  NUM_READ x DATA_W  corrected read data.
- bypass_hits  out  32  only with REGFILE_BYPASS_CNT_EN.

Behaviour:
- Cycle T (capture):
  - Register rd_valid, rd_address[IDX_W-1:0], and all wr_* fields.
  - A write port counts as active only if wr_write=1; its mask is zeroed when wr_write=0.
- Cycle T+1 (output):
  - out_valid[i] = captured rd_valid[i].
  - out_value[i] is combinational from sram_data[i] plus the captured writes.
  - For each byte k, start with sram_data[i] byte k. For write port j = 0..NUM_WRITE-1 in ascending order: if active, captured wr_address[j] index == captured rd index[i], and mask[j][k]=1, replace byte k with wr_value[j] byte k.
  - Highest-numbered write port wins per byte on multi-port collision.
- Latency: exactly 1 cycle, address to out_value. No backpressure; lanes are independent.
- out_value is driven regardless of valid. With out_valid=0, it must still equal the merge result; the bench checks it only when valid.
- Address compare uses IDX_W bits only: address 0x25 matches 0x05.
- All-zero mask with wr_write=1: no bytes forwarded.
- Writes in cycle T-1 or earlier are not forwarded; the SRAM already holds them.
- Reset (reset_n=0 at a rising edge):
  - Captured rd_valid and wr_write are cleared; captured addresses, data, and masks are set to 0.
  - Next cycle out_valid=0 and out_value=sram_data, since no forwarding happens.
  - Reads in flight at reset are dropped; there is no partial output.
- First cycle after reset release: out_valid=0.

Optional Feature:
- REGFILE_BYPASS_CNT_EN defined:
  - Adds output bypass_hits, a 32-bit saturating counter.
  - Increments by the number of lanes with out_valid=1 that had at least one byte forwarded this cycle (0..NUM_READ per cycle).
  - Saturates at 0xFFFFFFFF and clears on reset.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- regfile_pkg package holds:
  - Constants REGFILE_DATA_W=64, REGFILE_IDX_W=5, REGFILE_BYTES=8, REGFILE_NUM_READ=8, REGFILE_NUM_WRITE=4.
  - typedef struct regfile_wr_t {write, address, value, byteMask}.
  - typedef logic [REGFILE_BYTES-1:0] regfile_mask_t.
- One sub-module, regfile_bypass_lane:
  - Per read lane; takes the captured index, sram_data lane, and captured write array.
  - Produces the merged value and a hit flag.
  - Instantiated NUM_READ times via generate.

Test Plan:
- No collision: cycle T, read lane 0 addr 3 valid, write port 1 addr 4 mask 0xFF; T+1 sram_data[0]=0x1111_2222_3333_4444 -> out_valid[0]=1, out_value[0]=0x1111_2222_3333_4444.
- Partial forward: T, read lane 5 addr 7, write port 0 addr 7 value 0xAAAA_BBBB_CCCC_DDDD mask 0x0F; sram_data[5]=0 -> out_value[5]=0x0000_0000_CCCC_DDDD, hit flagged.
- Priority: T, read lane 2 addr 9, write port 0 value all 0x11, write port 3 value all 0x33, both mask 0xFF addr 9 -> out_value[2]=0x3333_3333_3333_3333.
- Aliasing and enable: T, read addr 0x45, write addr 0x05 mask 0xFF wr_write=1 -> forwarded. Repeat with wr_write=0 -> sram_data passes unchanged.
- Reset mid-flight: T, read lane 1 valid with colliding write; reset_n=0 at T's edge -> T+1 out_valid=0, out_value[1]=sram_data[1].
- REGFILE_BYPASS_CNT_EN: 3 lanes hit per cycle for 4 cycles -> bypass_hits=12. Preload near max -> holds 0xFFFFFFFF. Reset -> 0.
